// File: rtl/alu_pkg.sv
// alu_pkg: opcode, state and flag types shared by seq_alu and its iterative unit.
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_SHL    = 4'b0100,
    OP_SHR    = 4'b0101,
    OP_AND    = 4'b0110,
    OP_OR     = 4'b0111,
    OP_XOR    = 4'b1000,
    OP_POPCNT = 4'b1001,
    OP_CMP    = 4'b1010,
    OP_CMPS   = 4'b1011,
    OP_MUL    = 4'b1100
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  function automatic logic is_iter_op(input logic [3:0] opcode);
    return (opcode == OP_MUL) || (opcode == OP_POPCNT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shift-add multiplier and serial popcount sharing one counter
// and one 2*WIDTH accumulator; consumes one bit of b per step.
`default_nettype none

module alu_iter_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mode_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);

  localparam int AW = 2 * WIDTH;

  logic [AW-1:0]    acc;
  logic [AW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic             mul_q;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc_next;

  // result/hi_nonzero include the current step so the top can register them
  // on the same edge as the final iteration.
  always_comb begin
    addend = '0;
    if (b_sh[0]) begin
      addend = mul_q ? a_sh : {{(AW-1){1'b0}}, 1'b1};
    end
    acc_next = acc + addend;
  end

  assign last       = step && (cnt == CNT_W'(WIDTH - 1));
  assign result     = acc_next[WIDTH-1:0];
  assign hi_nonzero = |acc_next[AW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      mul_q <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      a_sh  <= {{WIDTH{1'b0}}, a};
      b_sh  <= b;
      cnt   <= '0;
      mul_q <= mode_mul;
    end else if (step) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with start/done handshake, registered result and NZCV
// flags, single-cycle datapath plus iterative MUL/POPCNT.
`default_nettype none

module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             optype,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] reg_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             op_err
);

  localparam int               MSB       = WIDTH - 1;
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  alu_state_e       state;
  alu_flags_t       flags;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic             pend;
  logic             accept;

  logic             iter_load;
  logic             iter_step;
  logic             iter_last;
  logic [WIDTH-1:0] iter_result;
  logic             iter_hi;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] s_out;
  alu_flags_t       s_flags;
  logic             s_err;
  logic             set_zn;

  // The first RUN cycle still shows busy=0, so the state gates acceptance too.
  assign accept    = start && !optype && !busy && (state == IDLE);
  assign iter_load = accept && is_iter_op(op);
  assign iter_step = (state == RUN);

  assign z = flags.z;
  assign n = flags.n;
  assign c = flags.c;
  assign v = flags.v;

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk        (clk),
    .reset      (reset),
    .load       (iter_load),
    .mode_mul   (op == OP_MUL),
    .a          (acc_in),
    .b          (reg_in),
    .step       (iter_step),
    .last       (iter_last),
    .result     (iter_result),
    .hi_nonzero (iter_hi)
  );

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    s_out   = out;
    s_flags = flags;
    s_err   = 1'b0;
    set_zn  = 1'b1;
    case (op_q)
      OP_ADD: begin
        s_out     = sum[WIDTH-1:0];
        s_flags.c = sum[WIDTH];
        s_flags.v = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        s_out     = diff[WIDTH-1:0];
        s_flags.c = diff[WIDTH];
        s_flags.v = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_SHL: begin
        s_out     = (b_q >= SHIFT_LIM) ? '0 : (a_q << b_q);
        s_flags.c = 1'b0;
        s_flags.v = 1'b0;
      end
      OP_SHR: begin
        s_out     = (b_q >= SHIFT_LIM) ? '0 : (a_q >> b_q);
        s_flags.c = 1'b0;
        s_flags.v = 1'b0;
      end
      OP_AND: begin
        s_out     = a_q & b_q;
        s_flags.c = 1'b0;
        s_flags.v = 1'b0;
      end
      OP_OR: begin
        s_out     = a_q | b_q;
        s_flags.c = 1'b0;
        s_flags.v = 1'b0;
      end
      OP_XOR: begin
        s_out     = a_q ^ b_q;
        s_flags.c = 1'b0;
        s_flags.v = 1'b0;
      end
      OP_CMP: begin
        s_flags.z = (a_q == b_q);
        s_flags.n = (a_q < b_q);
        set_zn    = 1'b0;
      end
      OP_CMPS: begin
        s_flags.z = (a_q == b_q);
        s_flags.n = ($signed(a_q) < $signed(b_q));
        set_zn    = 1'b0;
      end
      default: begin
        s_out  = '0;
        s_err  = 1'b1;
        set_zn = 1'b0;
      end
    endcase
    if (set_zn) begin
      s_flags.z = (s_out == '0);
      s_flags.n = s_out[MSB];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pend   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_err <= 1'b0;
      out    <= '0;
      flags  <= '0;
    end else begin
      done   <= 1'b0;
      op_err <= 1'b0;
      pend   <= accept && !is_iter_op(op);
      if (accept) begin
        a_q  <= acc_in;
        b_q  <= reg_in;
        op_q <= op;
        if (is_iter_op(op)) begin
          state <= RUN;
        end
      end
      // Single-cycle ops complete one edge after acceptance from latched operands.
      if (pend) begin
        done   <= 1'b1;
        op_err <= s_err;
        out    <= s_out;
        flags  <= s_flags;
      end
      if (state == RUN) begin
        busy <= !iter_last;
        if (iter_last) begin
          state   <= IDLE;
          done    <= 1'b1;
          out     <= iter_result;
          flags.z <= (iter_result == '0);
          flags.n <= iter_result[MSB];
          flags.c <= (op_q == OP_MUL) && iter_hi;
          flags.v <= (op_q == OP_MUL) && iter_hi;
        end
      end
    end
  end

endmodule

`default_nettype wire
